kernel_invoker: RTL and testbench
=================================

Name: kernel_invoker

Overview:
- Host-side driver for a synthesized single-call kernel such as fib-style `main`, i.e. the caller end of the kernel start/finish protocol.
- Accepts call requests `(n, a, b)` on a valid/ready port, pulses the kernel's `r_enable` with the arguments, and waits for the kernel's sticky `w_enable`.
- Returns the result on a valid/ready response port, with a cycle count and a timeout flag.
- Sits between the testbench/host fabric and one kernel instance.

Parameters:
- N_W, 6, width of argument n.
- D_W, 32, width of arguments a, b and of the result.
- CNT_W, 16, width of the cycle counter and the timeout compare.
- TIMEOUT, 1024, number of WAIT cycles before the call is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  call request valid
- req_ready  out  1  block can accept a call
- req_n  in  N_W  argument n
- req_a  in  D_W  argument a
- req_b  in  D_W  argument b
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  D_W  kernel result; 0 on timeout
- rsp_timeout  out  1  call abandoned
- rsp_cycles  out  CNT_W  WAIT cycles elapsed before w_enable was seen (saturating)
- busy  out  1  state != IDLE
- k_r_enable  out  1  kernel start pulse
- k_control_arr  out  1  tied 0
- k_init_n  out  N_W  kernel argument n
- k_init_a  out  D_W  kernel argument a
- k_init_b  out  D_W  kernel argument b
- k_w_enable  in  1  kernel done; level, sticky until the next r_enable
- k_result  in  D_W  kernel result; valid while k_w_enable=1

Behaviour:
- Reset values: state=IDLE; argument registers, rsp_data, rsp_cycles, rsp_timeout, rsp_valid, k_r_enable and busy are all 0.
- Reset mid-call aborts with no response. The kernel itself is not reset; the next LAUNCH restarts it.
- State IDLE:
  - req_ready=1.
  - On req_valid: latch n/a/b into argument registers, clear the counter, go to LAUNCH.
- State LAUNCH (exactly 1 cycle):
  - k_r_enable=1, then go to WAIT.
  - k_w_enable is ignored here because it can still be high from the previous call.
- k_init_* are driven from the argument registers continuously, so they are stable in LAUNCH and all later states.
- State WAIT:
  - The counter starts at 0 in the first WAIT cycle and increments by 1 each WAIT cycle, saturating at 2^CNT_W-1.
  - If k_w_enable=1: capture rsp_data=k_result, rsp_cycles=counter, rsp_timeout=0, go to HOLD.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: rsp_data=0, rsp_cycles=counter, rsp_timeout=1, go to HOLD.
  - If w_enable and timeout occur in the same cycle, w_enable wins (normal response).
- State HOLD:
  - rsp_valid=1; rsp_* stay stable until rsp_ready.
  - rsp_valid&rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - No new request is accepted in HOLD; req_ready=0 there.
- Latency:
  - Accept edge at cycle T; LAUNCH at T+1; first WAIT at T+2.
  - w_enable first seen in WAIT cycle k gives rsp_valid at cycle T+3+k.
- req_ready is a registered state decode and does not depend combinationally on req_valid or rsp_ready.

Decomposition:
- Package `kernel_invoker_pkg`:
  - state enum `invoker_state_t` {IDLE, LAUNCH, WAIT, HOLD}, 2-bit;
  - default width localparams N_W/D_W/CNT_W.
- No sub-module needed. An optional `sat_counter` (enable, clear, saturating) may be factored out.

Test Plan:
- Kernel model with done latency 5: req n=3,a=7,b=9 → k_r_enable high exactly 1 cycle at T+1 with k_init=(3,7,9); rsp_valid at T+8, rsp_cycles=5, rsp_timeout=0, rsp_data=model value.
- Stale done: model holds k_w_enable=1 from the previous call through LAUNCH and drops it on r_enable, then re-asserts after 3 cycles → no early response; rsp_cycles=3.
- Timeout with TIMEOUT=8 and a model that never asserts done → rsp_timeout=1, rsp_data=0, rsp_cycles=7, rsp_valid at T+10. A subsequent call completes normally.
- Same-cycle w_enable and timeout: model asserts done at WAIT cycle 7 with TIMEOUT=8 → rsp_timeout=0, data=k_result.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_* stable, req_ready=0, a second req_valid is not accepted. After the rsp_ready handshake, the second request is accepted from IDLE.
- Integration with the real fib kernel: n=10,a=0,b=1 gives rsp_data=55; n=0,a=42,b=0 gives rsp_data=42. Assert rst during WAIT → all outputs 0 asynchronously, no rsp_valid, next call correct.

Source files
------------

// File: rtl/kernel_invoker_pkg.sv
// Shared types and default widths for the kernel start/finish caller.
package kernel_invoker_pkg;

  localparam int N_W   = 6;
  localparam int D_W   = 32;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } invoker_state_t;

endpackage

// File: rtl/kernel_invoker.sv
// Caller end of a single-call kernel: launches the kernel with latched
// arguments, waits for its sticky done level, and returns the result with a cycle count.
module kernel_invoker
  import kernel_invoker_pkg::*;
#(
  parameter int          N_W     = kernel_invoker_pkg::N_W,
  parameter int          D_W     = kernel_invoker_pkg::D_W,
  parameter int          CNT_W   = kernel_invoker_pkg::CNT_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_W-1:0]   req_n,
  input  logic [D_W-1:0]   req_a,
  input  logic [D_W-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [D_W-1:0]   rsp_data,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             busy,
  output logic             k_r_enable,
  output logic             k_control_arr,
  output logic [N_W-1:0]   k_init_n,
  output logic [D_W-1:0]   k_init_a,
  output logic [D_W-1:0]   k_init_b,
  input  logic             k_w_enable,
  input  logic [D_W-1:0]   k_result
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  invoker_state_t   state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [D_W-1:0]   a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [D_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             to_q, to_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      cycles_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      cycles_q <= cycles_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    cycles_d = cycles_q;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          n_d     = req_n;
          a_d     = req_a;
          b_d     = req_b;
          cnt_d   = '0;
          state_d = LAUNCH;
        end
      end
      // Done may still be high from the previous call, so it is not looked at here.
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (k_w_enable) begin
          data_d   = k_result;
          cycles_d = cnt_q;
          to_d     = 1'b0;
          state_d  = HOLD;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          data_d   = '0;
          cycles_d = cnt_q;
          to_d     = 1'b1;
          state_d  = HOLD;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign k_r_enable    = (state_q == LAUNCH);
  assign rsp_valid     = (state_q == HOLD);
  assign rsp_data      = data_q;
  assign rsp_cycles    = cycles_q;
  assign rsp_timeout   = to_q;
  assign k_control_arr = 1'b0;
  assign k_init_n      = n_q;
  assign k_init_a      = a_q;
  assign k_init_b      = b_q;

endmodule

// File: tb/tb_kernel_invoker.sv
// Self-checking bench for kernel_invoker with a behavioural fib-style kernel model.
module tb_kernel_invoker;

  localparam int N_W   = 6;
  localparam int D_W   = 32;
  localparam int CNT_W = 16;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic             clk, rst;
  logic             req_valid, req_ready;
  logic [N_W-1:0]   req_n;
  logic [D_W-1:0]   req_a, req_b;
  logic             rsp_valid, rsp_ready, rsp_timeout;
  logic [D_W-1:0]   rsp_data;
  logic [CNT_W-1:0] rsp_cycles;
  logic             busy, k_r_enable, k_control_arr;
  logic [N_W-1:0]   k_init_n;
  logic [D_W-1:0]   k_init_a, k_init_b;
  logic             k_w_enable;
  logic [D_W-1:0]   k_result;

  int checks = 0;
  int errors = 0;

  kernel_invoker #(.N_W(N_W), .D_W(D_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_cycles(rsp_cycles),
    .busy(busy), .k_r_enable(k_r_enable), .k_control_arr(k_control_arr),
    .k_init_n(k_init_n), .k_init_a(k_init_a), .k_init_b(k_init_b),
    .k_w_enable(k_w_enable), .k_result(k_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [D_W-1:0] fib(input int n, input logic [D_W-1:0] a,
                                         input logic [D_W-1:0] b);
    logic [D_W-1:0] x, y, t;
    x = a;
    y = b;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Kernel model: done drops on r_enable and rises k_lat cycles into WAIT, then stays high.
  int   k_lat = 0;
  int   k_ctr = 0;
  bit   k_run = 1'b0;
  logic k_done = 1'b0;
  logic [D_W-1:0] k_res = '0;
  assign k_w_enable = k_done;
  assign k_result   = k_res;

  always @(posedge clk) begin
    if (k_r_enable) begin
      k_res <= fib(int'(k_init_n), k_init_a, k_init_b);
      if (k_lat == 0) begin
        k_done <= 1'b1;
        k_run  <= 1'b0;
      end else begin
        k_done <= 1'b0;
        k_ctr  <= k_lat - 1;
        k_run  <= 1'b1;
      end
    end else if (k_run) begin
      if (k_ctr == 0) begin
        k_done <= 1'b1;
        k_run  <= 1'b0;
      end else begin
        k_ctr <= k_ctr - 1;
      end
    end
  end

  typedef struct {
    int             n;
    logic [D_W-1:0] a;
    logic [D_W-1:0] b;
    int             lat;
    int             hold;
    logic [D_W-1:0] exp_data;
    int             exp_cycles;
    bit             exp_to;
    int             exp_lat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the response follows from the kernel latency and the timeout rule alone.
  function automatic vec_t ref_call(input int n, input logic [D_W-1:0] a,
                                    input logic [D_W-1:0] b, input int lat, input int hold);
    vec_t v;
    v.n = n; v.a = a; v.b = b; v.lat = lat; v.hold = hold;
    if (lat <= TMO - 1) begin
      v.exp_data = fib(n, a, b); v.exp_cycles = lat; v.exp_to = 1'b0; v.exp_lat = lat + 3;
    end else begin
      v.exp_data = '0; v.exp_cycles = TMO - 1; v.exp_to = 1'b1; v.exp_lat = TMO + 2;
    end
    return v;
  endfunction

  task automatic run_call(input vec_t v);
    int waitc, c, extra;
    logic [D_W-1:0] d0;
    k_lat = v.lat;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      step();
      waitc++;
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_n = N_W'(v.n);
    req_a = v.a;
    req_b = v.b;
    step();
    req_valid = 1'b0;
    chk("launch_r_enable", k_r_enable, 1);
    chk("launch_init_n", k_init_n, v.n);
    chk("launch_init_a", k_init_a, v.a);
    chk("launch_init_b", k_init_b, v.b);
    chk("launch_busy", busy, 1);
    c = 1;
    extra = 0;
    while (!rsp_valid && c < 60) begin
      step();
      c++;
      if (k_r_enable) extra++;
    end
    chk("rsp_latency", c, v.exp_lat);
    chk("r_enable_width", extra, 0);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_cycles", rsp_cycles, v.exp_cycles);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    $display("call n=%0d a=%0h b=%0h lat=%0d -> data=%0h cycles=%0d timeout=%0b after %0d cycles",
             v.n, v.a, v.b, v.lat, rsp_data, rsp_cycles, rsp_timeout, c);
    d0 = rsp_data;
    for (int h = 0; h < v.hold; h++) begin
      if (v.hold >= 10 && h == 0) begin
        req_valid = 1'b1;
        req_n = N_W'(9);
        req_a = 32'h1234;
      end
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, d0);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_init_n", k_init_n, v.n);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("after_handshake_valid", rsp_valid, 0);
    chk("after_handshake_ready", req_ready, 1);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    // n, a, b, lat, hold, exp_data, exp_cycles, exp_to, exp_lat
    tbl[0] = '{3, 7, 9, 5, 0, 25, 5, 1'b0, 8};       // basic, latency 5
    tbl[1] = '{1, 2, 3, 3, 1, 3, 3, 1'b0, 6};        // stale done from previous call
    tbl[2] = '{4, 1, 1, NEVER, 0, 0, 7, 1'b1, 10};   // timeout
    tbl[3] = '{10, 0, 1, 2, 0, 55, 2, 1'b0, 5};      // normal after timeout
    tbl[4] = '{0, 42, 0, 7, 0, 42, 7, 1'b0, 10};     // done and timeout same cycle
    tbl[5] = '{2, 5, 6, 0, 2, 11, 0, 1'b0, 3};       // done in first WAIT cycle
    tbl[6] = '{5, 0, 1, 4, 10, 5, 4, 1'b0, 7};       // backpressure with pending request
    tbl[7] = '{1, 1, 2, 8, 0, 0, 7, 1'b1, 10};       // done one cycle too late

    rst = 1'b1;
    req_valid = 1'b0; req_n = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_r_enable", k_r_enable, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_cycles", rsp_cycles, 0);
    chk("reset_control_arr", k_control_arr, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_call(tbl[i]);

    for (int i = 0; i < 20; i++) begin
      rv = ref_call(int'($urandom_range(0, 15)), D_W'($urandom), D_W'($urandom),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
      run_call(rv);
    end

    // Asynchronous reset in the middle of WAIT aborts the call.
    k_lat = NEVER;
    req_valid = 1'b1; req_n = N_W'(7); req_a = 32'h5; req_b = 32'h6;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    chk("midcall_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_init_n", k_init_n, 0);
    chk("async_rst_init_a", k_init_a, 0);
    chk("async_rst_req_ready", req_ready, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    run_call(ref_call(10, 0, 1, 6, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
